disp_bin2bcd: RTL
=================

# disp_bin2bcd

Sequential binary-to-digit converter that sits directly upstream of the four-digit multiplexed seven-segment driver. It accepts a binary value through a start/busy/done handshake. It converts the value to four decimal digits using iterative double-dabble, or passes it through as four hex nibbles. It holds the result on `d1`..`d4`, so the driver always sees a stable, glitch-free digit set.

## Interface
- `WIDTH`, default 16: width of input `value`. Legal range is 4..16. The internal BCD scratch is fixed at 5 digits (20 bits).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `hex`  in  1  sampled with `start`. 1 = hex passthrough; 0 = decimal conversion.
- `value`  in  WIDTH  binary operand; sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse on the cycle the new digits appear.
- `ovf`  out  1  decimal result exceeded 9999; held until the next `done`.
- `d1`  out  4  ones digit (rightmost display position).
- `d2`  out  4  tens digit.
- `d3`  out  4  hundreds digit.
- `d4`  out  4  thousands digit (leftmost display position).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, `start`=1 at edge N:
  - Latch `value`, zero-extended to 16 bits, into the shift register.
  - Latch `hex` and clear the 20-bit BCD scratch.
  - Next state is DONE if `hex`=1, otherwise SHIFT with iteration counter = 0.
- IDLE, `start`=0: no change.
- SHIFT, one iteration per cycle:
  - Each BCD nibble ≥5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Increment the counter.
- SHIFT exit: after iteration 16 completes (counter reaches 15 and performs its iteration), go to DONE. Exactly 16 iterations regardless of `WIDTH`, because the operand is zero-extended.
- DONE, decimal mode:
  - If BCD digit 4 (ten-thousands) is nonzero: `ovf`=1 and `d4..d1`=9,9,9,9 (saturate).
  - Otherwise: `ovf`=0 and `d4..d1` = BCD digits 3..0.
- DONE, hex mode: `d4..d1` = value[15:12], [11:8], [7:4], [3:0]; `ovf`=0.
- DONE always: `done`=1 for that single update cycle, then next state is IDLE.
- `d1`..`d4` and `ovf` are registers and change only on the DONE→IDLE edge. They hold their previous values throughout SHIFT.
- `start` outside IDLE, including during the DONE cycle, is ignored. It is not queued.
- Changes on `value` or `hex` after the sampling edge have no effect on the conversion in progress.

## Timing
- Reset (asynchronous, immediate): state = IDLE; `busy`=0, `done`=0, `ovf`=0, `d1`..`d4`=0.
- Reset asserted mid-conversion aborts it. No `done` is issued, and outputs return to the reset values.
- Decimal latency: `start` sampled at edge N → `busy`=1 after edges N..N+16 → at edge N+17 the digits update, `done`=1 and `busy`=0. The earliest next accepted `start` is at edge N+18.
- Hex latency: `start` at edge N → DONE after N, `busy`=1 for one cycle → at edge N+1 the digits update and `done`=1. The earliest next `start` is at edge N+2.
- `done` is registered, is high for exactly one cycle per accepted `start`, and is never high while a new conversion is running.
- Back-to-back: holding `start` high continuously yields one conversion every 18 cycles (decimal) or every 2 cycles (hex).

## Test plan
- Reset, then `value`=1234, `hex`=0, pulse `start` at edge N → `busy` high for 17 cycles, `done` at N+17, `d4..d1`=1,2,3,4, `ovf`=0.
- `value`=0, then `value`=9999 (decimal) → digits 0,0,0,0 then 9,9,9,9, `ovf`=0 in both cases. Check that digits stay unchanged while the second conversion is busy.
- `value`=10000, then `value`=65535 (decimal) → `ovf`=1 and `d4..d1`=9,9,9,9 for both. A following `value`=42 → `ovf`=0, digits 0,0,4,2.
- `value`=16'hBEEF, `hex`=1 → `done` at N+1, `d4..d1`=B,E,E,F, `ovf`=0.
- During a decimal conversion, pulse `start` with `value`=7 at N+5 and at N+17 → both ignored, one `done` only, result from the original operand. A `start` at N+18 is accepted.
- Assert `rst` at N+8 of a 4321 conversion → all outputs 0 immediately, no `done`. After release, a new conversion of 4321 completes normally in 17 cycles.

Source files
------------

// File: rtl/disp_bin2bcd.sv
// Binary-to-digit converter feeding the 4-digit seven-segment driver.
// Double-dabble over a 16-bit zero-extended operand, or hex nibble passthrough.
module disp_bin2bcd #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hex,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       d1,
   output logic [3:0]       d2,
   output logic [3:0]       d3,
   output logic [3:0]       d4
);

   localparam int unsigned BIN_W   = 16;
   localparam int unsigned BCD_W   = 20;
   localparam int unsigned BCD_N   = 5;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned DIGIT_W = 16;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state, state_nxt;
   logic [BIN_W-1:0]   bin_q, bin_nxt;
   logic [BCD_W-1:0]   bcd_q, bcd_nxt, bcd_adj;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               hex_q, hex_nxt;
   logic               busy_nxt, done_nxt, ovf_nxt;
   logic [DIGIT_W-1:0] digits_nxt;

   // Add-3 correction of every BCD nibble that is 5 or more
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < int'(BCD_N); i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nxt  = state;
      bin_nxt    = bin_q;
      bcd_nxt    = bcd_q;
      cnt_nxt    = cnt_q;
      hex_nxt    = hex_q;
      done_nxt   = 1'b0;
      ovf_nxt    = ovf;
      digits_nxt = {d4, d3, d2, d1};

      case (state)
         IDLE: begin
            if (start) begin
               bin_nxt   = BIN_W'(value);
               hex_nxt   = hex;
               bcd_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = hex ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            {bcd_nxt, bin_nxt} = (BCD_W + BIN_W)'({bcd_adj, bin_q, 1'b0});
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1))
               state_nxt = DONE;
         end
         DONE: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            if (hex_q) begin
               ovf_nxt    = 1'b0;
               digits_nxt = bin_q;
            end else if (bcd_q[BCD_W-1 -: 4] != 4'd0) begin
               // Ten-thousands digit set: saturate the four-digit display
               ovf_nxt    = 1'b1;
               digits_nxt = 16'h9999;
            end else begin
               ovf_nxt    = 1'b0;
               digits_nxt = bcd_q[DIGIT_W-1:0];
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         bin_q            <= '0;
         bcd_q            <= '0;
         cnt_q            <= '0;
         hex_q            <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         ovf              <= 1'b0;
         {d4, d3, d2, d1} <= '0;
      end else begin
         state            <= state_nxt;
         bin_q            <= bin_nxt;
         bcd_q            <= bcd_nxt;
         cnt_q            <= cnt_nxt;
         hex_q            <= hex_nxt;
         busy             <= busy_nxt;
         done             <= done_nxt;
         ovf              <= ovf_nxt;
         {d4, d3, d2, d1} <= digits_nxt;
      end
   end

endmodule
